// File: rtl/mem_lsu_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
// Holds the FSM state type, load/store width codes and the misalignment rule.
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [3:0] WEB_NONE = 4'b1111;

  // Access size comes from funct3[1:0]; unknown codes behave as word accesses.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] lane);
    case (funct3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return lane[0];
      default: return lane != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_load_align.sv
// Load result formatter: picks the addressed byte/half out of the read word
// and sign- or zero-extends it according to funct3.
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   result = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  result = {24'h0, byte_sel};
      F3_LHU:  result = {16'h0, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: issues data-memory requests, stalls the pipeline
// while they are outstanding, and formats load data. Option: LSU_MISALIGN_CHK_EN.
//
// state  | meaning
// IDLE   | no access in flight; a new load/store is latched here
// REQ    | request presented, waiting for grant
// WAIT   | granted, waiting for response (timeout counter runs)
// DONE   | result visible; held while the instruction side stalls
module mem_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int RESP_TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mem_read_i,
  input  logic              mem_store_i,
  input  logic [2:0]        mem_funct3_i,
  input  logic [3:0]        mem_web_i,
  input  logic [31:0]       mem_wdata_i,
  input  logic [31:0]       mem_addr_i,
  input  logic              stall_im_i,
  output logic              dm_req_o,
  output logic              dm_we_o,
  output logic [ADDR_W-1:0] dm_addr_o,
  output logic [3:0]        dm_web_o,
  output logic [31:0]       dm_wdata_o,
  input  logic              dm_gnt_i,
  input  logic              dm_rvalid_i,
  input  logic [31:0]       dm_rdata_i,
  output logic              stall_dm_o,
  output logic [31:0]       lsu_rdata_o,
  output logic              lsu_err_o
);

  localparam int CNT_W = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESP_TIMEOUT - 1);

  lsu_state_e        state, state_next;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        web_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic [31:0]       load_fmt;
  logic [2:0]        funct3_q;
  logic              store_q;
  logic              err_q;
  logic [CNT_W-1:0]  cnt_q;

  logic access, latch, load_done, err_set, timeout_hit, misaligned, busy;

  assign access = mem_read_i | mem_store_i;

`ifdef LSU_MISALIGN_CHK_EN
  assign misaligned = is_misaligned(mem_funct3_i, mem_addr_i[1:0]);
`else
  assign misaligned = 1'b0;
`endif

  assign timeout_hit = (RESP_TIMEOUT != 0) && (cnt_q == CNT_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    latch      = 1'b0;
    load_done  = 1'b0;
    err_set    = 1'b0;
    case (state)
      S_IDLE: begin
        if (access) begin
          latch = 1'b1;
          if (misaligned) begin
            state_next = S_DONE;
            err_set    = 1'b1;
          end else begin
            state_next = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (dm_gnt_i && dm_rvalid_i) begin
          state_next = S_DONE;
          load_done  = ~store_q;
        end else if (dm_gnt_i) begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (dm_rvalid_i) begin
          state_next = S_DONE;
          load_done  = ~store_q;
        end else if (timeout_hit) begin
          state_next = S_DONE;
          err_set    = 1'b1;
        end
      end
      S_DONE: begin
        if (!stall_im_i) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q   <= '0;
      web_q    <= WEB_NONE;
      wdata_q  <= '0;
      funct3_q <= '0;
      store_q  <= 1'b0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= err_set;
      if (latch) begin
        addr_q   <= mem_addr_i[ADDR_W-1:0];
        web_q    <= mem_web_i;
        wdata_q  <= mem_wdata_i;
        funct3_q <= mem_funct3_i;
        store_q  <= mem_store_i;
        cnt_q    <= '0;
      end else if (state == S_WAIT && cnt_q != '1) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (load_done)    rdata_q <= load_fmt;
      else if (err_set) rdata_q <= '0;
    end
  end

  load_align u_load_align (
    .rdata  (dm_rdata_i),
    .funct3 (funct3_q),
    .lane   (addr_q[1:0]),
    .result (load_fmt)
  );

  // Write strobes only leave the unit while a store is actually in flight.
  always_comb begin
    busy       = (state == S_REQ) || (state == S_WAIT);
    dm_req_o   = (state == S_REQ);
    dm_we_o    = busy && store_q;
    dm_web_o   = (busy && store_q) ? web_q : WEB_NONE;
    stall_dm_o = ((state == S_IDLE) && access) || busy;
  end

  assign dm_addr_o   = {addr_q[ADDR_W-1:2], 2'b00};
  assign dm_wdata_o  = wdata_q;
  assign lsu_rdata_o = rdata_q;
  assign lsu_err_o   = err_q;

endmodule
